// File: rtl/div_arb_pkg.sv
// Shared types and constants for the round-robin divider arbiter.
// Imported by div_arbiter and its interface users.
package div_arb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ISSUE = ST_ISSUE,
        WAIT  = ST_WAIT,
        RESP  = ST_RESP
    } state_e;

    // Quotient reported for a bypassed divide-by-zero; truncated to W at use.
    localparam int unsigned    ZDIV_MAX_W = 64;
    localparam logic [ZDIV_MAX_W-1:0] ZDIV_QUO = '1;

    // Requester index width for n requesters, never below one bit.
    function automatic int unsigned idw_of(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/div_arbiter_if.sv
// Client-side and divider-side signal bundle of div_arbiter.
interface div_arbiter_if #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 8
);
    logic [N-1:0]   req;
    logic [N*W-1:0] dvnd_in;
    logic [N*W-1:0] dvsr_in;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic [W-1:0]   quo_out;
    logic [W-1:0]   rmd_out;
    logic           err_out;
    logic           busy;
    logic           div_start;
    logic [W-1:0]   div_dvnd;
    logic [W-1:0]   div_dvsr;
    logic           div_ready;
    logic           div_done_tick;
    logic [W-1:0]   div_quo;
    logic [W-1:0]   div_rmd;

    modport slave (
        input  req, dvnd_in, dvsr_in, div_ready, div_done_tick, div_quo, div_rmd,
        output gnt, done, quo_out, rmd_out, err_out, busy, div_start, div_dvnd, div_dvsr
    );

    modport master (
        output req, dvnd_in, dvsr_in, div_ready, div_done_tick, div_quo, div_rmd,
        input  gnt, done, quo_out, rmd_out, err_out, busy, div_start, div_dvnd, div_dvsr
    );
endinterface

// File: rtl/div_arbiter_rr_pick.sv
// Combinational round-robin selector: first set req bit at or above ptr, wrapping.
module rr_pick #(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [IDW-1:0] sel,
    output logic           any
);

    always_comb begin : pick
        int unsigned idx;
        sel = '0;
        any = 1'b0;
        idx = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr) + k) % N;
            if (!any && req[IDW'(idx)]) begin
                any = 1'b1;
                sel = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// Round-robin owner of one shared sequential divider among N requesters.
// Optional DIV_ARB_ZERO_CHK_EN: zero divisors bypass the divider and flag err_out.
module div_arbiter
    import div_arb_pkg::*;
#(
    parameter int unsigned N   = 4,
    parameter int unsigned W   = 8,
    parameter int unsigned IDW = idw_of(N)
) (
    input logic           clk,
    input logic           reset,
    div_arbiter_if.slave  bus
);

    state_e         state_q, state_d;
    logic [IDW-1:0] ptr_q, owner_q, sel;
    logic           any, take;
    logic [W-1:0]   sel_dvnd, sel_dvsr;
    logic [W-1:0]   dvnd_q, dvsr_q, quo_q, rmd_q;
    logic [N-1:0]   gnt_c, done_d, done_q;
    logic           start_d, start_q, busy_d, busy_q;

    rr_pick #(.N(N), .IDW(IDW)) u_pick (
        .req (bus.req),
        .ptr (ptr_q),
        .sel (sel),
        .any (any)
    );

    assign sel_dvnd = bus.dvnd_in[32'(sel)*W +: W];
    assign sel_dvsr = bus.dvsr_in[32'(sel)*W +: W];
    assign take     = (state_q == IDLE) && any && bus.div_ready;

`ifdef DIV_ARB_ZERO_CHK_EN
    logic zero_sel;
    logic err_q;
    assign zero_sel    = (sel_dvsr == '0);
    assign bus.err_out = err_q;
`else
    assign bus.err_out = 1'b0;
`endif

    // Next state plus the one-cycle pulses, registered below.
    always_comb begin
        state_d = state_q;
        gnt_c   = '0;
        start_d = 1'b0;
        done_d  = '0;
        case (state_q)
            IDLE: begin
                if (take) begin
                    gnt_c[sel] = 1'b1;
                    state_d    = ISSUE;
                    start_d    = 1'b1;
`ifdef DIV_ARB_ZERO_CHK_EN
                    if (zero_sel) begin
                        state_d     = RESP;
                        start_d     = 1'b0;
                        done_d[sel] = 1'b1;
                    end
`endif
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (bus.div_done_tick) begin
                    state_d         = RESP;
                    done_d[owner_q] = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            dvnd_q  <= '0;
            dvsr_q  <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            start_q <= 1'b0;
            done_q  <= '0;
            busy_q  <= 1'b0;
`ifdef DIV_ARB_ZERO_CHK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            if (take) begin
                owner_q <= sel;
                dvnd_q  <= sel_dvnd;
                dvsr_q  <= sel_dvsr;
            end
            if (state_q == WAIT && bus.div_done_tick) begin
                quo_q <= bus.div_quo;
                rmd_q <= bus.div_rmd;
`ifdef DIV_ARB_ZERO_CHK_EN
                err_q <= 1'b0;
`endif
            end
`ifdef DIV_ARB_ZERO_CHK_EN
            if (take && zero_sel) begin
                quo_q <= W'(ZDIV_QUO);
                rmd_q <= sel_dvnd;
                err_q <= 1'b1;
            end
`endif
            // Pointer moves just past the owner so it becomes lowest priority.
            if (state_q == RESP)
                ptr_q <= (owner_q == IDW'(N-1)) ? '0 : owner_q + IDW'(1);
        end
    end

    assign bus.gnt       = gnt_c;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;
    assign bus.div_start = start_q;
    assign bus.div_dvnd  = dvnd_q;
    assign bus.div_dvsr  = dvsr_q;
    assign bus.quo_out   = quo_q;
    assign bus.rmd_out   = rmd_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Randomized bench for div_arbiter with a transaction-level arbiter model
// and a behavioural variable-latency restoring divider.
module tb_div_arbiter;
    localparam int unsigned N   = 4;
    localparam int unsigned W   = 8;
    localparam int unsigned IDW = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    div_arbiter_if #(.N(N), .W(W)) bus ();
    div_arbiter #(.N(N), .W(W), .IDW(IDW)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Stimulus state (applied just after each rising edge)
    logic [N-1:0] req_v;
    logic [W-1:0] a_v [N];
    logic [W-1:0] b_v [N];
    logic ready_blk_n = 1'b0, ready_blk = 1'b0, spur_n = 1'b0, spur = 1'b0;
    bit hold_req = 1'b0, rand_on = 1'b0;
    int lat_force = -1;

    // Behavioural divider: results of a restoring divider, random latency
    logic dv_busy, tick_q;
    int dv_cnt;
    logic [W-1:0] dq, dr;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dv_busy <= 1'b0; tick_q <= 1'b0; dv_cnt <= 0; dq <= '0; dr <= '0;
        end else begin
            tick_q <= 1'b0;
            if (dv_busy) begin
                if (dv_cnt == 0) begin
                    dv_busy <= 1'b0;
                    tick_q  <= 1'b1;
                end else dv_cnt <= dv_cnt - 1;
            end else if (bus.div_start) begin
                dv_busy <= 1'b1;
                dv_cnt  <= (lat_force >= 0) ? lat_force : int'($urandom_range(6, 0));
                dq <= (bus.div_dvsr == '0) ? '1 : bus.div_dvnd / bus.div_dvsr;
                dr <= (bus.div_dvsr == '0) ? bus.div_dvnd : bus.div_dvnd % bus.div_dvsr;
            end
        end
    end
    assign bus.div_ready     = !dv_busy && !ready_blk;
    assign bus.div_done_tick = tick_q | spur;
    assign bus.div_quo       = dq;
    assign bus.div_rmd       = dr;

    // Transaction-level arbiter model
    bit in_flight, start_due, done_due, waiting, exp_e, last_e;
    int ptr_m, owner_m, age, n_done, n_start;
    logic [W-1:0] op_a, op_b, exp_q, exp_r, last_q, last_r;
    int gq[$];

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            int unsigned idx = (p + k) % N;
            if (r[idx[IDW-1:0]]) return int'(idx);
        end
        return -1;
    endfunction

    task automatic model_cycle();
        logic [N-1:0] exp_g;
        int w;
        bit nd, ns;
        exp_g = '0; w = -1; nd = 1'b0; ns = 1'b0;
        if (!in_flight && req_v != '0 && bus.div_ready) begin
            w = pick(req_v, ptr_m);
            exp_g = N'(1) << w;
        end
        check("gnt", 64'(bus.gnt), 64'(exp_g));
        check("busy", 64'(bus.busy), 64'(in_flight));
        check("div_start", 64'(bus.div_start), 64'(start_due));
        if (start_due) begin
            check("div_dvnd", 64'(bus.div_dvnd), 64'(op_a));
            check("div_dvsr", 64'(bus.div_dvsr), 64'(op_b));
        end
        check("done", 64'(bus.done), done_due ? 64'(N'(1) << owner_m) : 64'(0));
        if (done_due) begin
            last_q = exp_q; last_r = exp_r; last_e = exp_e;
        end
        check("quo_out", 64'(bus.quo_out), 64'(last_q));
        check("rmd_out", 64'(bus.rmd_out), 64'(last_r));
        check("err_out", 64'(bus.err_out), 64'(last_e));

        if (bus.div_start) n_start++;
        if (waiting && bus.div_done_tick) begin nd = 1'b1; waiting = 1'b0; end
        if (start_due) waiting = 1'b1;
        if (done_due) begin
            in_flight = 1'b0; ptr_m = (owner_m + 1) % N; n_done++;
        end
        if (in_flight) begin
            age++;
            if (age > 200) begin
                check("op_timeout", 64'(age), 64'(0));
                in_flight = 1'b0; waiting = 1'b0; nd = 1'b0;
            end
        end
        if (w >= 0) begin
            in_flight = 1'b1; age = 0; owner_m = w;
            op_a = a_v[w]; op_b = b_v[w];
            gq.push_back(w);
            exp_q = (op_b == '0) ? '1 : op_a / op_b;
            exp_r = (op_b == '0) ? op_a : op_a % op_b;
            exp_e = 1'b0;
`ifdef DIV_ARB_ZERO_CHK_EN
            if (op_b == '0) begin exp_e = 1'b1; nd = 1'b1; end
            else ns = 1'b1;
`else
            ns = 1'b1;
`endif
        end
        start_due = ns;
        done_due  = nd;
    endtask

    task automatic clients();
        for (int i = 0; i < N; i++)
            if (bus.gnt[i] && !hold_req) req_v[i] = 1'b0;
        if (rand_on) begin
            for (int i = 0; i < N; i++) begin
                if (!req_v[i] && $urandom_range(4, 0) == 0) begin
                    req_v[i] = 1'b1;
                    a_v[i] = W'($urandom);
                    b_v[i] = ($urandom_range(5, 0) == 0) ? '0 : W'($urandom_range(40, 1));
                end
            end
            ready_blk_n = ($urandom_range(7, 0) == 0);
            spur_n = !in_flight && ($urandom_range(5, 0) == 0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        bus.req = req_v;
        for (int i = 0; i < N; i++) begin
            bus.dvnd_in[i*W +: W] = a_v[i];
            bus.dvsr_in[i*W +: W] = b_v[i];
        end
        ready_blk = ready_blk_n;
        spur = spur_n;
        @(negedge clk);
        if (!reset) model_cycle();
        clients();
    endtask

    task automatic run_idle(input int budget);
        int c = 0;
        while ((in_flight || start_due || done_due || req_v != '0) && c < budget) begin
            step();
            c++;
        end
        if (c >= budget) check("drain_timeout", 64'(c), 64'(0));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        req_v = '0; bus.req = '0;
        ready_blk_n = 1'b0; ready_blk = 1'b0; spur_n = 1'b0; spur = 1'b0; hold_req = 1'b0;
        #1;
        check("rst_gnt", 64'(bus.gnt), 64'(0));
        check("rst_done", 64'(bus.done), 64'(0));
        check("rst_quo", 64'(bus.quo_out), 64'(0));
        check("rst_rmd", 64'(bus.rmd_out), 64'(0));
        check("rst_err", 64'(bus.err_out), 64'(0));
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_start", 64'(bus.div_start), 64'(0));
        check("rst_dvnd", 64'(bus.div_dvnd), 64'(0));
        check("rst_dvsr", 64'(bus.div_dvsr), 64'(0));
        in_flight = 0; start_due = 0; done_due = 0; waiting = 0;
        ptr_m = 0; owner_m = 0; age = 0;
        last_q = '0; last_r = '0; last_e = 1'b0;
        gq.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin : main
        int s0, d0, c;
        req_v = '0;
        bus.dvnd_in = '0; bus.dvsr_in = '0; bus.req = '0;
        for (int i = 0; i < N; i++) begin a_v[i] = '0; b_v[i] = '1; end
        n_done = 0; n_start = 0;
        do_reset();

        // Single request 200/7 from client 2
        s0 = n_start;
        req_v[2] = 1'b1; a_v[2] = 8'd200; b_v[2] = 8'd7;
        run_idle(100);
        check("single_owner", 64'(gq.size() > 0 ? gq[0] : -1), 64'(2));
        check("single_quo", 64'(bus.quo_out), 64'(28));
        check("single_rmd", 64'(bus.rmd_out), 64'(4));
        check("single_err", 64'(bus.err_out), 64'(0));
        check("single_starts", 64'(n_start - s0), 64'(1));

        // Contention with all requests held high
        do_reset();
        hold_req = 1'b1;
        for (int i = 0; i < N; i++) begin a_v[i] = W'(i*50 + 10); b_v[i] = 8'd3; end
        req_v = '1;
        d0 = n_done; c = 0;
        while (n_done - d0 < 4 && c < 400) begin step(); c++; end
        req_v = '0; hold_req = 1'b0;
        run_idle(100);
        check("cont_count", 64'(gq.size()), 64'(4));
        for (int k = 0; k < 4 && k < gq.size(); k++) check("cont_order", 64'(gq[k]), 64'(k));

        // Fairness wrap: pointer sits at 0 after client 3
        gq.delete();
        a_v[0] = 8'd77; b_v[0] = 8'd5; a_v[3] = 8'd250; b_v[3] = 8'd16;
        req_v = 4'b1001;
        run_idle(100);
        check("wrap_first", 64'(gq.size() > 0 ? gq[0] : -1), 64'(0));
        check("wrap_second", 64'(gq.size() > 1 ? gq[1] : -1), 64'(3));

        // Divider not ready holds off the grant
        s0 = n_start; d0 = gq.size();
        ready_blk_n = 1'b1;
        req_v[1] = 1'b1; a_v[1] = 8'd100; b_v[1] = 8'd9;
        repeat (5) step();
        check("rdy_no_start", 64'(n_start - s0), 64'(0));
        check("rdy_no_gnt", 64'(gq.size() - d0), 64'(0));
        ready_blk_n = 1'b0;
        step();
        check("rdy_gnt", 64'(bus.gnt), 64'(4'b0010));
        run_idle(100);

        // Zero divisor
        s0 = n_start;
        req_v[0] = 1'b1; a_v[0] = 8'h5A; b_v[0] = 8'h00;
        run_idle(100);
        check("zero_quo", 64'(bus.quo_out), 64'(8'hFF));
        check("zero_rmd", 64'(bus.rmd_out), 64'(8'h5A));
`ifdef DIV_ARB_ZERO_CHK_EN
        check("zero_err", 64'(bus.err_out), 64'(1));
        check("zero_starts", 64'(n_start - s0), 64'(0));
`else
        check("zero_err", 64'(bus.err_out), 64'(0));
        check("zero_starts", 64'(n_start - s0), 64'(1));
`endif

        // Reset while waiting on the divider
        req_v[2] = 1'b1; a_v[2] = 8'd90; b_v[2] = 8'd4;
        run_idle(100);
        lat_force = 10;
        s0 = n_start; c = 0;
        req_v[1] = 1'b1; a_v[1] = 8'd123; b_v[1] = 8'd10;
        while (n_start == s0 && c < 20) begin step(); c++; end
        check("wait_started", 64'(n_start - s0), 64'(1));
        repeat (2) step();
        check("wait_busy", 64'(bus.busy), 64'(1));
        do_reset();
        lat_force = -1;
        a_v[1] = 8'd60; b_v[1] = 8'd7; a_v[3] = 8'd61; b_v[3] = 8'd8;
        req_v = 4'b1010;
        step();
        check("post_rst_gnt", 64'(bus.gnt), 64'(4'b0010));
        run_idle(100);

        // Random traffic with spurious ticks and divider stalls
        rand_on = 1'b1;
        repeat (3000) step();
        rand_on = 1'b0; ready_blk_n = 1'b0; spur_n = 1'b0;
        run_idle(500);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
